// File: rtl/mnist_capture_ctrl_pkg.sv
// mnist_pkg: types and defaults shared by the MNIST capture controller,
// its window generator, its bus interface and its testbench.
//   ctrl_state_t - controller FSM states
//   IMG_DIM / IMG_PIXELS - captured image side and pixel count
//   DEF_* - default box position, blanking offsets and buffer address width
package mnist_pkg;

    localparam int IMG_DIM    = 28;
    localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
    localparam int CNT_W      = 13;

    localparam int DEF_X_MIN          = 305;
    localparam int DEF_Y_MIN          = 225;
    localparam int DEF_H_BLANK_OFFSET = 160;
    localparam int DEF_V_BLANK_OFFSET = 45;
    localparam int DEF_ADDR_W         = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_START,
        ST_WAIT_DONE
    } ctrl_state_t;

endpackage

// File: rtl/mnist_capture_ctrl_if.sv
// mnist_capture_ctrl_if: all non-clock signals of the capture controller.
//   VGA side   : VGA_H_CNT, VGA_V_CNT, BIN_PIXVAL (controller inputs)
//   Request    : CAPTURE_REQ (level, in)
//   Buffer     : WR_EN, WR_ADDR, WR_DATA (out)
//   Classifier : CLS_START (out), CLS_READY, CLS_DONE, CLS_RESULT (in)
//   Status     : DIGIT, DIGIT_VALID, BUSY (out)
// Handshake: a classifier start is transferred on the clock edge where
// CLS_START and CLS_READY are both high; CLS_START stays high until then.
// Modport master is the controller, slave is its environment.
interface mnist_capture_ctrl_if #(
    parameter int ADDR_W = mnist_pkg::DEF_ADDR_W
);
    import mnist_pkg::*;

    logic              CAPTURE_REQ;
    logic [CNT_W-1:0]  VGA_H_CNT;
    logic [CNT_W-1:0]  VGA_V_CNT;
    logic [7:0]        BIN_PIXVAL;
    logic              WR_EN;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [7:0]        WR_DATA;
    logic              CLS_START;
    logic              CLS_READY;
    logic              CLS_DONE;
    logic [3:0]        CLS_RESULT;
    logic [3:0]        DIGIT;
    logic              DIGIT_VALID;
    logic              BUSY;

    modport master (
        input  CAPTURE_REQ, VGA_H_CNT, VGA_V_CNT, BIN_PIXVAL,
        input  CLS_READY, CLS_DONE, CLS_RESULT,
        output WR_EN, WR_ADDR, WR_DATA, CLS_START,
        output DIGIT, DIGIT_VALID, BUSY
    );

    modport slave (
        output CAPTURE_REQ, VGA_H_CNT, VGA_V_CNT, BIN_PIXVAL,
        output CLS_READY, CLS_DONE, CLS_RESULT,
        input  WR_EN, WR_ADDR, WR_DATA, CLS_START,
        input  DIGIT, DIGIT_VALID, BUSY
    );

endinterface

// File: rtl/mnist_capture_ctrl_roi_window_gen.sv
// roi_window_gen: decodes the VGA counters (blanking included).
//   vga_h_cnt, vga_v_cnt in  - raw counters
//   in_win               out - counters inside the box interior (border excluded)
//   frame_start          out - counters at (0,0)
// Purely combinational; the controller registers everything it drives out.
module roi_window_gen #(
    parameter int X_MIN          = mnist_pkg::DEF_X_MIN,
    parameter int Y_MIN          = mnist_pkg::DEF_Y_MIN,
    parameter int H_BLANK_OFFSET = mnist_pkg::DEF_H_BLANK_OFFSET,
    parameter int V_BLANK_OFFSET = mnist_pkg::DEF_V_BLANK_OFFSET,
    parameter int IMG_DIM        = mnist_pkg::IMG_DIM
) (
    input  logic [mnist_pkg::CNT_W-1:0] vga_h_cnt,
    input  logic [mnist_pkg::CNT_W-1:0] vga_v_cnt,
    output logic                        in_win,
    output logic                        frame_start
);
    import mnist_pkg::*;

    // The +1 skips the box border line/column drawn by the overlay.
    localparam logic [CNT_W-1:0] H_LO = CNT_W'(X_MIN + H_BLANK_OFFSET + 1);
    localparam logic [CNT_W-1:0] H_HI = CNT_W'(X_MIN + H_BLANK_OFFSET + IMG_DIM);
    localparam logic [CNT_W-1:0] V_LO = CNT_W'(Y_MIN + V_BLANK_OFFSET + 1);
    localparam logic [CNT_W-1:0] V_HI = CNT_W'(Y_MIN + V_BLANK_OFFSET + IMG_DIM);

    always_comb begin
        in_win      = (vga_h_cnt >= H_LO) && (vga_h_cnt <= H_HI) &&
                      (vga_v_cnt >= V_LO) && (vga_v_cnt <= V_HI);
        frame_start = (vga_h_cnt == '0) && (vga_v_cnt == '0);
    end

endmodule

// File: rtl/mnist_capture_ctrl.sv
// mnist_capture_ctrl: captures the 28x28 binarized box interior into the
// classifier image buffer, starts the classifier and holds its result.
//   CLK       in  - VGA pixel clock
//   RST       in  - asynchronous active-high reset
//   bus       if  - VGA counters/pixel, capture request, buffer write port,
//                   classifier handshake and digit status (master side)
//   dbg_state out - current FSM state
// Every bus output is a flop; the write strobe lags the selecting counters
// by one clock.
module mnist_capture_ctrl #(
    parameter int X_MIN          = mnist_pkg::DEF_X_MIN,
    parameter int Y_MIN          = mnist_pkg::DEF_Y_MIN,
    parameter int H_BLANK_OFFSET = mnist_pkg::DEF_H_BLANK_OFFSET,
    parameter int V_BLANK_OFFSET = mnist_pkg::DEF_V_BLANK_OFFSET,
    parameter int IMG_DIM        = mnist_pkg::IMG_DIM,
    parameter int ADDR_W         = mnist_pkg::DEF_ADDR_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    mnist_capture_ctrl_if.master    bus,
    output mnist_pkg::ctrl_state_t  dbg_state
);
    import mnist_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_DIM * IMG_DIM - 1);

    ctrl_state_t       state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              cls_start_q, cls_start_d;
    logic [3:0]        digit_q, digit_d;
    logic              digit_valid_q, digit_valid_d;
    logic              busy_q, busy_d;
    logic              in_win;
    logic              frame_start;

    roi_window_gen #(
        .X_MIN          (X_MIN),
        .Y_MIN          (Y_MIN),
        .H_BLANK_OFFSET (H_BLANK_OFFSET),
        .V_BLANK_OFFSET (V_BLANK_OFFSET),
        .IMG_DIM        (IMG_DIM)
    ) u_roi (
        .vga_h_cnt   (bus.VGA_H_CNT),
        .vga_v_cnt   (bus.VGA_V_CNT),
        .in_win      (in_win),
        .frame_start (frame_start)
    );

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        cls_start_d   = 1'b0;
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.CAPTURE_REQ) begin
                    state_d       = ST_ARMED;
                    digit_valid_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    state_d   = ST_CAPTURE;
                    pix_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                // A new frame before the image is complete restarts it from
                // address 0; the partially written buffer is just overwritten.
                if (frame_start) begin
                    pix_cnt_d = '0;
                end else if (in_win) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_cnt_q;
                    wr_data_d = bus.BIN_PIXVAL;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == LAST_ADDR) begin
                        state_d     = ST_START;
                        cls_start_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                // cls_start_q is high throughout START, so CLS_READY alone
                // marks the transfer edge.
                if (bus.CLS_READY) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cls_start_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.CLS_DONE) begin
                    state_d       = ST_IDLE;
                    digit_d       = bus.CLS_RESULT;
                    digit_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            pix_cnt_q     <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            cls_start_q   <= 1'b0;
            digit_q       <= '0;
            digit_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            cls_start_q   <= cls_start_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.WR_EN       = wr_en_q;
    assign bus.WR_ADDR     = wr_addr_q;
    assign bus.WR_DATA     = wr_data_q;
    assign bus.CLS_START   = cls_start_q;
    assign bus.DIGIT       = digit_q;
    assign bus.DIGIT_VALID = digit_valid_q;
    assign bus.BUSY        = busy_q;
    assign dbg_state       = state_q;

endmodule
